imem_loader: RTL and testbench

//  UART boot loader feeding the core's instruction RAM write port (ADDR/DIN/wren).

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_rx.sv | 85 ++++++++
 rtl/imem_loader.sv | 98 +++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-RAM boot loader.
// Holds the loader and RX state encodings and the bit-timing helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_COUNT,
    LD_DATA,
    LD_WRITE,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int WORDS_MAX = 256;
  localparam int WL_W      = 9;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/imem_loader_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit glitch reject, and
// a one-cycle byte_valid or frame_err_pulse at the stop-bit centre.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err_pulse
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  logic             sync1, sync2, sync3;
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             fall, bit_tick, half_tick;

  assign fall      = sync3 & ~sync2;
  assign bit_tick  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt == CNT_W'(HALF_BIT - 1));
  assign data      = shift;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= RX_IDLE;
    else        state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_next      = state;
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (half_tick) state_next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP: begin
        if (bit_tick) begin
          state_next      = RX_IDLE;
          byte_valid      = sync2;
          frame_err_pulse = ~sync2;
        end
      end
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state_next != state || state == RX_IDLE || bit_tick) cnt <= '0;
      else                                                     cnt <= cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && bit_tick) begin
        shift   <= {sync2, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// UART boot loader: length byte N (0 means 256), then N little-endian words
// written to IRAM from address 0; core_hold releases once the image is in.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rx,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_din,
  output logic              imem_wren,
  output logic              core_hold,
  output logic              done,
  output logic              frame_err,
  output logic [WL_W-1:0]   words_left
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);

  ld_state_t  state, state_next;
  logic       byte_valid, frame_err_pulse;
  logic [7:0] rx_data;
  logic [1:0] byte_idx;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
    .clock           (clock),
    .clear           (clear),
    .rx              (rx),
    .byte_valid      (byte_valid),
    .data            (rx_data),
    .frame_err_pulse (frame_err_pulse)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= LD_COUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LD_COUNT: begin
        if (frame_err_pulse) state_next = LD_ERR;
        else if (byte_valid) state_next = LD_DATA;
      end
      LD_DATA: begin
        if (frame_err_pulse)                      state_next = LD_ERR;
        else if (byte_valid && byte_idx == 2'd3)  state_next = LD_WRITE;
      end
      LD_WRITE: begin
        if (frame_err_pulse)       state_next = LD_ERR;
        else if (words_left == 1)  state_next = LD_DONE;
        else                       state_next = LD_DATA;
      end
      LD_DONE:  state_next = LD_DONE;
      LD_ERR:   state_next = LD_ERR;
      default:  state_next = LD_ERR;
    endcase
  end

  // Outputs decode straight from the state register, so they are glitch-free.
  assign imem_wren = (state == LD_WRITE);
  assign done      = (state == LD_DONE);
  assign core_hold = (state != LD_DONE);
  assign frame_err = (state == LD_ERR);

  // NOTE: only the loader registers are reset; IRAM itself keeps its contents across clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      imem_addr  <= '0;
      imem_din   <= '0;
      words_left <= '0;
      byte_idx   <= '0;
    end else begin
      case (state)
        LD_COUNT: if (byte_valid) begin
          words_left <= (rx_data == 8'd0) ? WL_W'(WORDS_MAX) : WL_W'(rx_data);
          byte_idx   <= '0;
        end
        LD_DATA: if (byte_valid) begin
          imem_din[8*byte_idx +: 8] <= rx_data;
          byte_idx                  <= byte_idx + 1'b1;
        end
        LD_WRITE: begin
          imem_addr  <= imem_addr + 1'b1;
          words_left <= words_left - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a 16-clock/bit instance for the directed
// scenarios and a 4-clock/bit instance for the full 256-word load.
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] din;
  } wr_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, rx, clear_f, rx_f;
  logic [7:0]  addr, addr_f;
  logic [31:0] din, din_f;
  logic        wren, wren_f, hold, hold_f, done, done_f, ferr, ferr_f;
  logic [8:0]  wl, wl_f;

  imem_loader #(.CLK_HZ(16), .BAUD(1), .ADDR_W(8), .DATA_W(32)) dut (
    .clock(clock), .clear(clear), .rx(rx), .imem_addr(addr), .imem_din(din),
    .imem_wren(wren), .core_hold(hold), .done(done), .frame_err(ferr), .words_left(wl)
  );

  imem_loader #(.CLK_HZ(4), .BAUD(1), .ADDR_W(8), .DATA_W(32)) dut_f (
    .clock(clock), .clear(clear_f), .rx(rx_f), .imem_addr(addr_f), .imem_din(din_f),
    .imem_wren(wren_f), .core_hold(hold_f), .done(done_f), .frame_err(ferr_f), .words_left(wl_f)
  );

  wr_t exp_q[$];
  wr_t exp_qf[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit fast, input logic v);
    if (fast) rx_f = v;
    else      rx   = v;
  endtask

  task automatic send_byte(input bit fast, input logic [7:0] b, input bit stop_ok, input int idle_bits);
    int         n;
    logic [9:0] frame;
    n     = fast ? 4 : 16;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(fast, frame[i]);
      cycles(n);
    end
    drive(fast, 1'b1);
    cycles(n * idle_bits);
  endtask

  task automatic wait_done(input bit fast, input string name);
    int k = 0;
    while (!(fast ? done_f : done) && k < 400) begin
      cycles(1);
      k++;
    end
    check(name, fast ? done_f : done, 1);
  endtask

  task automatic reset_main();
    clear = 1'b0;
    cycles(2);
    clear = 1'b1;
    cycles(2);
  endtask

  task automatic check_reset_main(input string tag);
    check({tag, "_hold"}, hold, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_ferr"}, ferr, 0);
    check({tag, "_wl"},   wl,   0);
    check({tag, "_wren"}, wren, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_din"},  din,  0);
  endtask

  // Monitor for the main instance: every write strobe is matched against the queue.
  logic prev_wren = 1'b0, prev_hold = 1'b1;
  always @(negedge clock) begin
    wr_t e;
    if (wren) begin
      check("wren_single_cycle", prev_wren, 0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wren: addr %0h din %0h, expected no write", addr, din);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", addr, e.addr);
        check("wr_din", din, e.din);
      end
    end
    if (prev_hold && !hold) check("hold_falls_after_wren", prev_wren, 1);
    prev_wren = wren;
    prev_hold = hold;
  end

  always @(negedge clock) begin
    wr_t e;
    if (wren_f) begin
      if (exp_qf.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wren_fast: addr %0h din %0h, expected no write", addr_f, din_f);
      end else begin
        e = exp_qf.pop_front();
        check("wr_addr_fast", addr_f, e.addr);
        check("wr_din_fast", din_f, e.din);
      end
    end
  end

  initial begin
    rx      = 1'b1;
    rx_f    = 1'b1;
    clear   = 1'b0;
    clear_f = 1'b0;
    cycles(3);
    check_reset_main("reset");
    clear   = 1'b1;
    clear_f = 1'b1;
    cycles(2);

    fork
      begin : full_load
        logic [7:0] i8;
        for (int i = 0; i < 256; i++) begin
          i8 = 8'(i);
          exp_qf.push_back('{addr: i8, din: {~i8, 8'h3C, i8 ^ 8'hA5, i8}});
        end
        send_byte(1'b1, 8'h00, 1'b1, 0);
        for (int i = 0; i < 256; i++) begin
          i8 = 8'(i);
          send_byte(1'b1, i8, 1'b1, 0);
          send_byte(1'b1, i8 ^ 8'hA5, 1'b1, 0);
          send_byte(1'b1, 8'h3C, 1'b1, 0);
          send_byte(1'b1, ~i8, 1'b1, 0);
        end
        wait_done(1'b1, "full_done");
        check("full_addr_wrap", addr_f, 0);
        check("full_wl", wl_f, 0);
        check("full_hold", hold_f, 0);
      end

      begin : directed
        // Two-word image.
        exp_q.push_back('{addr: 8'd0, din: 32'h0010_0093});
        exp_q.push_back('{addr: 8'd1, din: 32'h0020_0113});
        send_byte(1'b0, 8'h02, 1'b1, 2);
        send_byte(1'b0, 8'h93, 1'b1, 2);
        send_byte(1'b0, 8'h00, 1'b1, 2);
        send_byte(1'b0, 8'h10, 1'b1, 2);
        send_byte(1'b0, 8'h00, 1'b1, 2);
        send_byte(1'b0, 8'h13, 1'b1, 2);
        send_byte(1'b0, 8'h01, 1'b1, 2);
        send_byte(1'b0, 8'h20, 1'b1, 2);
        send_byte(1'b0, 8'h00, 1'b1, 2);
        wait_done(1'b0, "two_word_done");
        check("two_word_hold", hold, 0);
        check("two_word_wl", wl, 0);
        check("two_word_addr", addr, 2);

        // Bad stop bit locks the loader in the error state.
        reset_main();
        send_byte(1'b0, 8'h01, 1'b1, 1);
        send_byte(1'b0, 8'h55, 1'b0, 2);
        check("ferr_set", ferr, 1);
        check("ferr_hold", hold, 1);
        check("ferr_done", done, 0);
        send_byte(1'b0, 8'h11, 1'b1, 1);
        send_byte(1'b0, 8'h22, 1'b1, 1);
        send_byte(1'b0, 8'h33, 1'b1, 1);
        send_byte(1'b0, 8'h44, 1'b1, 1);
        check("ferr_sticky", ferr, 1);
        check("ferr_hold_sticky", hold, 1);

        // Short low glitch while idle must not produce a byte.
        reset_main();
        rx = 1'b0;
        cycles(6);
        rx = 1'b1;
        cycles(40);
        check("glitch_wl", wl, 0);
        check("glitch_ferr", ferr, 0);
        check("glitch_hold", hold, 1);

        // Reset mid-load abandons the image and restarts at address 0.
        exp_q.push_back('{addr: 8'd0, din: 32'h4433_2211});
        send_byte(1'b0, 8'h03, 1'b1, 1);
        send_byte(1'b0, 8'h11, 1'b1, 1);
        send_byte(1'b0, 8'h22, 1'b1, 1);
        send_byte(1'b0, 8'h33, 1'b1, 1);
        send_byte(1'b0, 8'h44, 1'b1, 1);
        send_byte(1'b0, 8'h55, 1'b1, 1);
        send_byte(1'b0, 8'h66, 1'b1, 1);
        check("midload_wl", wl, 2);
        check("midload_addr", addr, 1);
        clear = 1'b0;
        cycles(2);
        check_reset_main("midreset");
        clear = 1'b1;
        cycles(2);
        exp_q.push_back('{addr: 8'd0, din: 32'hDDCC_BBAA});
        send_byte(1'b0, 8'h01, 1'b1, 1);
        send_byte(1'b0, 8'hAA, 1'b1, 1);
        send_byte(1'b0, 8'hBB, 1'b1, 1);
        send_byte(1'b0, 8'hCC, 1'b1, 1);
        send_byte(1'b0, 8'hDD, 1'b1, 1);
        wait_done(1'b0, "reload_done");
        check("reload_addr", addr, 1);

        // Back-to-back frames, then trailing bytes after DONE.
        reset_main();
        exp_q.push_back('{addr: 8'd0, din: 32'h8765_4321});
        send_byte(1'b0, 8'h01, 1'b1, 0);
        send_byte(1'b0, 8'h21, 1'b1, 0);
        send_byte(1'b0, 8'h43, 1'b1, 0);
        send_byte(1'b0, 8'h65, 1'b1, 0);
        send_byte(1'b0, 8'h87, 1'b1, 0);
        send_byte(1'b0, 8'hEE, 1'b1, 0);
        send_byte(1'b0, 8'hFF, 1'b1, 2);
        wait_done(1'b0, "b2b_done");
        check("b2b_addr", addr, 1);
        check("b2b_wl", wl, 0);
        check("b2b_din", din, 32'h8765_4321);
        check("b2b_hold", hold, 0);
      end
    join

    cycles(4);
    check("pending_writes", exp_q.size(), 0);
    check("pending_writes_fast", exp_qf.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
